// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: write-buffer entry, FSM state,
// bus command encodings and the word-index width helper.
package dmem_pkg;

  // Bus command encodings, kept identical to sys_defs.vh.
  // BUS_NA behaves like BUS_NONE.
  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;
  localparam logic [1:0] BUS_NA    = 2'h3;

  // Widest possible word index of a 32-bit byte address. Entries carry the
  // index zero-extended to this width, so the struct does not depend on DEPTH.
  localparam int WIDX_W = 30;

  typedef struct packed {
    logic [WIDX_W-1:0] idx;
    logic [31:0]       data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LWAIT = 2'd1,
    LDONE = 2'd2
  } dmem_state_t;

  // Number of word-index bits for an array of 'depth' words.
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage bus between the pipeline (master) and the data-memory responder (slave).
//
// Handshake: the master presents mem_cmd/mem_addr/mem_din. A command is
// taken in a cycle where mem_stall is 0. While mem_stall is 1 the master
// holds all command inputs stable. Load data on mem_dout is valid in the
// cycle the load completes, which is the cycle mem_stall drops back to 0.
interface dmem_responder_if;
  logic [1:0]  mem_cmd;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_stall;

  modport master (
    output mem_cmd, mem_addr, mem_din,
    input  mem_dout, mem_stall
  );

  modport slave (
    input  mem_cmd, mem_addr, mem_din,
    output mem_dout, mem_stall
  );
endinterface

// File: rtl/dmem_wbuf.sv
// Circular write buffer: posts stores, drains oldest-first, and offers a
// combinational youngest-match lookup for store-to-load forwarding.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int WB_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  wb_entry_t                 push_entry,
  input  logic                      pop,
  output wb_entry_t                 head_entry,
  output logic [$clog2(WB_DEPTH):0] count,
  output logic                      full,
  input  logic [WIDX_W-1:0]         lookup_idx,
  output logic                      hit,
  output logic [31:0]               hit_data
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(WB_DEPTH);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] lk_slot;
  wb_entry_t     entries_q [WB_DEPTH];

  // Pointer and occupancy update; pointers wrap naturally at WB_DEPTH.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers, cleared by reset (pending entries are dropped).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (push) entries_q[tail_q] <= push_entry;
  end

  // Walk entries oldest to youngest so the last match (youngest) wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    lk_slot  = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      lk_slot = head_q + PW'(i);
      if ((i < int'(count_q)) && (entries_q[lk_slot].idx == lookup_idx)) begin
        hit      = 1'b1;
        hit_data = entries_q[lk_slot].data;
      end
    end
  end

  assign head_entry = entries_q[head_q];
  assign count      = count_q;
  assign full       = (count_q == FULL_CNT);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target end of the MEM-stage bus. Stores post into
// the write buffer (one cycle unless full); loads stall for LOAD_LAT cycles
// and return forwarded buffer data or the array word.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int WB_DEPTH = 4,
  parameter int LOAD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus,
  output logic            wb_empty,
  output dmem_state_t     dbg_state
);

  localparam int IDXW = idx_width(DEPTH);
  localparam int CW   = $clog2(LOAD_LAT + 1);

  dmem_state_t     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [31:0]     dout_q, dout_d;
  logic [31:0]     mem_q [DEPTH];

  logic            cmd_load, cmd_store;
  logic            stall_c;
  logic [IDXW-1:0] req_idx, rd_idx;
  logic [31:0]     load_word;

  logic                      wb_push, wb_pop, wb_full, wb_hit;
  wb_entry_t                 wb_push_entry, wb_head;
  logic [$clog2(WB_DEPTH):0] wb_count;
  logic [31:0]               wb_hit_data;
  logic                      unused_bits;

  // Command decode; BUS_NA is treated as no command.
  always_comb begin
    cmd_load  = 1'b0;
    cmd_store = 1'b0;
    case (bus.mem_cmd)
      BUS_LOAD:         cmd_load  = 1'b1;
      BUS_STORE:        cmd_store = 1'b1;
      BUS_NONE, BUS_NA: ;
      default:          ;
    endcase
  end

  assign req_idx = bus.mem_addr[IDXW+1:2];
  // In IDLE the lookup follows the live address (needed when LOAD_LAT=1);
  // otherwise it uses the captured load index.
  assign rd_idx    = (state_q == IDLE) ? req_idx : idx_q;
  assign load_word = wb_hit ? wb_hit_data : mem_q[rd_idx];

  assign wb_push_entry.idx  = WIDX_W'(req_idx);
  assign wb_push_entry.data = bus.mem_din;

  // Load FSM, store acceptance and drain decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    stall_c = 1'b0;
    wb_push = 1'b0;
    wb_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        // Drain yields only to a starting load.
        wb_pop = (wb_count != '0) && !cmd_load;
        if (cmd_load) begin
          stall_c = 1'b1;
          idx_d   = req_idx;
          cnt_d   = CW'(LOAD_LAT - 1);
          if (LOAD_LAT == 1) begin
            state_d = LDONE;
            dout_d  = load_word;
          end else begin
            state_d = LWAIT;
          end
        end else if (cmd_store) begin
          if (wb_full) stall_c = 1'b1;
          else         wb_push = 1'b1;
        end
      end
      LWAIT: begin
        stall_c = 1'b1;
        // Buffer and array are frozen while waiting, so sampling the
        // forwarded value on the way into LDONE equals sampling in LDONE.
        if (cnt_q == CW'(1)) begin
          state_d = LDONE;
          dout_d  = load_word;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LDONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and output registers; reset abandons any load in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
    end
  end

  // Single-port word array, written by the buffer drain only.
  always_ff @(posedge clk) begin
    if (wb_pop) mem_q[wb_head.idx[IDXW-1:0]] <= wb_head.data;
  end

  dmem_wbuf #(
    .WB_DEPTH (WB_DEPTH)
  ) u_wbuf (
    .clk        (clk),
    .rst_n      (rst),
    .push       (wb_push),
    .push_entry (wb_push_entry),
    .pop        (wb_pop),
    .head_entry (wb_head),
    .count      (wb_count),
    .full       (wb_full),
    .lookup_idx (WIDX_W'(rd_idx)),
    .hit        (wb_hit),
    .hit_data   (wb_hit_data)
  );

  // Stall is forced low while reset is asserted.
  assign bus.mem_stall = rst & stall_c;
  assign bus.mem_dout  = dout_q;
  assign wb_empty      = (wb_count == '0);
  assign dbg_state     = state_q;

  assign unused_bits = ^{bus.mem_addr[31:IDXW+2], bus.mem_addr[1:0],
                         wb_head.idx[WIDX_W-1:IDXW]};

endmodule
